// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared constants, types and hazard helper for the MIPS pipeline.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int         REG_W           = 5;
    localparam logic [2:0] TUSE_NONE       = 3'd7;
    localparam logic [2:0] TNEW_MAX        = 3'd3;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [2:0]       tcnt_t;

    typedef struct packed {
        logic rs_e;
        logic rs_m;
        logic rt_e;
        logic rt_m;
        logic md;
    } hazard_vec_t;

    // Read-after-write hazard: the producer's result arrives later than the consumer needs it.
    // $0 is hard-wired to zero, so it never carries a dependency.
    function automatic logic raw_hazard(
        input reg_idx_t src,
        input tcnt_t    tuse,
        input reg_idx_t dst,
        input logic     wen,
        input tcnt_t    tnew
    );
        return (src != '0) && wen && (dst == src) && (tnew > tuse);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_counter.sv
// ============================================================================
// Module  : md_busy_counter
// Brief   : Multiply/divide occupancy counter; busy while the count is nonzero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // A start arriving while the unit is still counting is dropped; the
    // stall logic upstream prevents that from happening in legal code.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_start && (r_cnt == '0)) begin
            r_cnt <= i_div ? C_DIV_LOAD : C_MULT_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : D-stage stall decision from register and multiply/divide hazards.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1D,
    input  logic [4:0]  A2D,
    input  logic [2:0]  TuseRsD,
    input  logic [2:0]  TuseRtD,
    input  logic [4:0]  A3E,
    input  logic        RFenE,
    input  logic [2:0]  TnewE,
    input  logic [4:0]  A3M,
    input  logic        RFenM,
    input  logic [2:0]  TnewM,
    input  logic        MDUseD,
    input  logic        MDStartE,
    input  logic        MDDivE,
    output logic        Stall,
    output logic        PCen,
    output logic        DRegen,
    output logic        EFlush,
    output logic        MDBusy,
    output logic [31:0] StallCnt
);

    hazard_vec_t w_haz;
    logic        w_stall;
    logic        w_md_busy;
    logic [31:0] r_stall_cnt;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy (
        .clk     (clk),
        .reset   (reset),
        .i_start (MDStartE),
        .i_div   (MDDivE),
        .o_busy  (w_md_busy)
    );

    always_comb begin
        w_haz      = '0;
        w_haz.rs_e = raw_hazard(A1D, TuseRsD, A3E, RFenE, TnewE);
        w_haz.rs_m = raw_hazard(A1D, TuseRsD, A3M, RFenM, TnewM);
        w_haz.rt_e = raw_hazard(A2D, TuseRtD, A3E, RFenE, TnewE);
        w_haz.rt_m = raw_hazard(A2D, TuseRtD, A3M, RFenM, TnewM);
        // The start cycle itself must stall: the counter only loads on this edge.
        w_haz.md   = MDUseD && (MDStartE || w_md_busy);
    end

    assign w_stall = |w_haz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign Stall    = w_stall;
    assign PCen     = ~w_stall;
    assign DRegen   = ~w_stall;
    assign EFlush   = w_stall;
    assign MDBusy   = w_md_busy;
    assign StallCnt = r_stall_cnt;

endmodule

`default_nettype wire
